// File: rtl/hsv_core_timer_if.sv
// Register request/response bundle for the core-local machine timer.
// The master drives requests and response acceptance; the timer is the slave.
interface hsv_core_timer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/hsv_core_timer.sv
// Core-local machine timer: 64-bit mtime/mtimecmp behind a single-outstanding
// 32-bit register port, raising irq_core while mtime >= mtimecmp.
module hsv_core_timer #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic              clk_core,
    input  logic              rst_core,
    hsv_core_timer_if.slave   bus,
    output logic              irq_core
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    typedef enum logic {
        IDLE,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;
    logic        irq_q;

    logic        tick;
    logic        accept;
    logic        addr_err;
    logic        do_write;
    logic [31:0] rd_val;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    assign tick     = (presc_q == PRESC_LAST);
    assign presc_d  = tick ? 16'd0 : presc_q + 16'd1;
    assign accept   = bus.req_valid && (state_q == IDLE);
    assign addr_err = (bus.req_addr[1:0] != 2'b00);
    assign do_write = accept && bus.req_write && !addr_err;

    always_comb begin
        rd_val = 32'd0;
        case (bus.req_addr[3:2])
            2'd0: rd_val = mtime_q[31:0];
            2'd1: rd_val = mtime_q[63:32];
            2'd2: rd_val = mtimecmp_q[31:0];
            2'd3: rd_val = mtimecmp_q[63:32];
            default: rd_val = 32'd0;
        endcase
    end

    // A write to either mtime half replaces that cycle's increment entirely.
    always_comb begin
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        if (do_write) begin
            case (bus.req_addr[3:2])
                2'd0: mtime_d = {mtime_q[63:32],
                                 merge_bytes(mtime_q[31:0], bus.req_wdata, bus.req_wstrb)};
                2'd1: mtime_d = {merge_bytes(mtime_q[63:32], bus.req_wdata, bus.req_wstrb),
                                 mtime_q[31:0]};
                2'd2: mtimecmp_d = {mtimecmp_q[63:32],
                                    merge_bytes(mtimecmp_q[31:0], bus.req_wdata, bus.req_wstrb)};
                2'd3: mtimecmp_d = {merge_bytes(mtimecmp_q[63:32], bus.req_wdata, bus.req_wstrb),
                                    mtimecmp_q[31:0]};
                default: mtime_d = mtime_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        error_d = error_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RESP;
                    rdata_d = (bus.req_write || addr_err) ? 32'd0 : rd_val;
                    error_d = addr_err;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                    rdata_d = 32'd0;
                    error_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            state_q    <= IDLE;
            presc_q    <= 16'd0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            rdata_q    <= 32'd0;
            error_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            rdata_q    <= rdata_d;
            error_q    <= error_d;
            irq_q      <= (mtime_q >= mtimecmp_q);
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_error = error_q;
    assign irq_core       = irq_q;

endmodule

// File: doc/hsv_core_timer.md
# hsv_core_timer

Core-local machine timer for the ScaleCore-V hart. It sits directly upstream of the core's `irq_core` input. It holds a 64-bit free-running `mtime` counter and a 64-bit `mtimecmp` compare register, both exposed through a single-outstanding 32-bit register request/response port. It asserts `irq_core` while `mtime >= mtimecmp` (unsigned).

## Interface
Parameters:
- `PRESCALE`, default 1: number of `clk_core` cycles per `mtime` increment; legal range 1..65535.

Ports:
- `clk_core`  in  1  core clock; all logic on its rising edge.
- `rst_core`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  register request valid.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  4  byte offset: 0x0 `mtime[31:0]`, 0x4 `mtime[63:32]`, 0x8 `mtimecmp[31:0]`, 0xC `mtimecmp[63:32]`.
- `req_wdata`  in  32  write data.
- `req_wstrb`  in  4  byte enables for writes; ignored on reads.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  response consumed when `resp_valid && resp_ready`.
- `resp_rdata`  out  32  read data; 0 for writes and errors.
- `resp_error`  out  1  1 when `req_addr[1:0] != 0`.
- `irq_core`  out  1  machine timer interrupt request, registered.

## Operation
- Reset values while `rst_core` is high:
  - `mtime` = 0, `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF, prescaler count = 0.
  - `irq_core` = 0, `resp_valid` = 0, `resp_rdata` = 0, `resp_error` = 0.
  - FSM in IDLE, so `req_ready` = 1.
  - Reset asserted mid-transaction drops any pending response with no handshake.
- FSM has two states:
  - IDLE: `req_ready` = 1. On accept, capture the response and go to RESP.
  - RESP: `req_ready` = 0, `resp_valid` = 1. On `resp_ready`, go to IDLE.
  - No back-to-back accept: at most one transaction every 2 cycles.
- Prescaler counts 0..PRESCALE-1 and wraps. `tick` = (count == PRESCALE-1). With PRESCALE=1, `tick` is 1 every cycle. The prescaler runs regardless of bus activity.
- On `tick`, `mtime` <= `mtime` + 1 modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- Writes:
  - Byte lanes with `req_wstrb` set are updated in the accepted half-register; other lanes hold.
  - A write to either `mtime` half suppresses the increment in that cycle. The prescaler is not reset.
  - A `mtimecmp` write does not affect counting.
  - An error request (misaligned address) writes nothing.
- Reads return the register value in the acceptance cycle, before that cycle's tick or write.
- There is no atomic 64-bit read; software uses the hi/lo/hi retry sequence.
- `irq_core` <= (`mtime >= mtimecmp`), evaluated on current register values every cycle, independent of bus state.

## Timing
- Request-to-response latency: `resp_valid` rises on the edge that accepts the request, i.e. it is visible the cycle after acceptance.
- `resp_rdata`, `resp_error` and `resp_valid` hold stable until `resp_ready`.
- A register write becomes visible in the register on the acceptance edge. `irq_core` reflects it one edge later, i.e. 2 cycles after the request cycle.
- When the tick-driven crossing `mtime == mtimecmp` occurs at edge N, `irq_core` rises at edge N+1.
- `irq_core` deasserts one edge after `mtimecmp` is raised above `mtime` or `mtime` is written below `mtimecmp`.

## Test plan
- Reset then idle, PRESCALE=1 -> `irq_core`=0, `req_ready`=1. Read 0x0 after 10 cycles from reset release returns the tick count (±1 for the acceptance edge); `resp_error`=0.
- Write 0x8 = 5, `wstrb`=4'hF; write 0xC = 0 -> `irq_core` rises exactly one cycle after `mtime` reaches 5 and stays high.
- Write 0x0 = 32'hFFFF_FFFF and 0x4 = 32'hFFFF_FFFF, then let one tick occur -> `mtime` = 0. Subsequent reads of 0x0 and 0x4 return 0 and 0 (±ticks elapsed). `irq_core` drops if `mtimecmp` > 0.
- PRESCALE=4 -> `mtime` increments once every 4 cycles. A write to 0x0 coinciding with a tick leaves `mtime[31:0]` equal to the written value, with no +1 in that cycle.
- Partial write: `wstrb`=4'b0010 with `wdata`=32'h0000_AB00 to 0x8 (was 0xFFFF_FFFF) -> a read returns 32'hFFFF_ABFF.
- Request to 0x6 -> `resp_error`=1, `resp_rdata`=0, no register change. Hold `resp_ready`=0 for 5 cycles -> `resp_valid` and `req_ready`=0 stay for all 5. Assert `rst_core` during RESP -> `resp_valid`=0 immediately.
